// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch stage (IF) and the
// data stage (MEM). MEM normally has priority; a saturating starvation
// counter hands the port to IF after STARVE_MAX MEM grants while IF waited.
//
// Handshake: a requester holds its request (if_req / mem_rd / mem_wr) until it
// sees its one-cycle done pulse. On the memory side m_req and its payload stay
// stable until m_ready is seen high; m_ready is a single-cycle completion that
// may come any number (>=1) of cycles after m_req rises, and is ignored
// whenever no grant is outstanding.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              freeze,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_starve
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic mem_any;
  assign mem_any = mem_rd | mem_wr;

  // State and all registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      starve_q    <= starve_d;
    end
  end

  // Next-state: arbitration in IDLE, wait for m_ready in GNT_x, one RESP cycle.
  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    starve_d    = starve_q;
    case (state_q)
      IDLE: begin
        if (if_req && (!mem_any || starve_q == STARVE_LIM)) begin
          state_d  = GNT_IF;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = if_addr;
          starve_d = '0;
        end else if (mem_any) begin
          state_d   = GNT_MEM;
          m_req_d   = 1'b1;
          // Read and write together is a write.
          m_we_d    = mem_wr;
          m_addr_d  = mem_addr;
          m_wdata_d = mem_wdata;
          if (if_req && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      GNT_IF: begin
        if (m_ready) begin
          state_d    = RESP;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_rdata_d = m_rdata;
          if_done_d  = 1'b1;
        end
      end
      GNT_MEM: begin
        if (m_ready) begin
          state_d = RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (!m_we_q) begin
            mem_rdata_d = m_rdata;
          end
          mem_done_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall the pipeline while a request is pending or being served.
  always_comb begin
    freeze = 1'b0;
    case (state_q)
      IDLE:    freeze = if_req | mem_any;
      GNT_IF:  freeze = 1'b1;
      GNT_MEM: freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_done    = if_done_q;
  assign mem_done   = mem_done_q;
  assign dbg_state  = state_q;
  assign dbg_starve = 8'(starve_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change and outputs are sampled
// on the falling clock edge; the design updates on the rising edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GNT_IF  = 2'd1;
  localparam logic [1:0] S_GNT_MEM = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              freeze;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic [1:0]        dbg_state;
  logic [7:0]        dbg_starve;

  int n_checks;
  int n_errors;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .freeze     (freeze),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .dbg_state  (dbg_state),
    .dbg_starve (dbg_starve)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m_rdata   = '0;
    m_ready   = 1'b0;

    // Reset state
    step();
    step();
    check_val("rst_state", dbg_state, S_IDLE);
    check_val("rst_m_req", m_req, 0);
    check_val("rst_m_we", m_we, 0);
    check_val("rst_m_addr", m_addr, 0);
    check_val("rst_m_wdata", m_wdata, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_mem_rdata", mem_rdata, 0);
    check_val("rst_if_done", if_done, 0);
    check_val("rst_mem_done", mem_done, 0);
    check_val("rst_starve", dbg_starve, 0);
    check_val("rst_freeze_idle", freeze, 0);

    // Requests during reset: no grant, freeze follows IDLE rule
    if_req = 1'b1;
    mem_rd = 1'b1;
    step();
    check_val("rst_req_no_grant", m_req, 0);
    check_val("rst_req_state", dbg_state, S_IDLE);
    check_val("rst_req_freeze", freeze, 1);
    if_req = 1'b0;
    mem_rd = 1'b0;
    rst    = 1'b1;
    step();

    // IF only, minimum latency
    if_req  = 1'b1;
    if_addr = 32'h10;
    step();
    check_val("if_state_gnt", dbg_state, S_GNT_IF);
    check_val("if_m_req", m_req, 1);
    check_val("if_m_we", m_we, 0);
    check_val("if_m_addr", m_addr, 32'h10);
    check_val("if_freeze_gnt", freeze, 1);
    m_ready = 1'b1;
    m_rdata = 32'hDEADBEEF;
    step();
    check_val("if_done", if_done, 1);
    check_val("if_rdata", if_rdata, 32'hDEADBEEF);
    check_val("if_freeze_resp", freeze, 0);
    check_val("if_m_req_clr", m_req, 0);
    check_val("if_mem_done_quiet", mem_done, 0);
    m_ready = 1'b0;
    if_req  = 1'b0;
    step();
    check_val("if_done_pulse_end", if_done, 0);
    check_val("if_back_idle", dbg_state, S_IDLE);
    check_val("if_freeze_idle", freeze, 0);

    // IF and MEM write together: MEM first, then IF
    if_req    = 1'b1;
    if_addr   = 32'h20;
    mem_wr    = 1'b1;
    mem_addr  = 32'h40;
    mem_wdata = 32'h55;
    step();
    check_val("pri_state_mem", dbg_state, S_GNT_MEM);
    check_val("pri_m_we", m_we, 1);
    check_val("pri_m_addr", m_addr, 32'h40);
    check_val("pri_m_wdata", m_wdata, 32'h55);
    check_val("pri_starve1", dbg_starve, 1);
    m_ready = 1'b1;
    m_rdata = 32'h1111;
    step();
    check_val("pri_mem_done", mem_done, 1);
    check_val("pri_if_done_quiet", if_done, 0);
    check_val("pri_mem_rdata_kept", mem_rdata, 0);
    check_val("pri_if_rdata_kept", if_rdata, 32'hDEADBEEF);
    check_val("pri_m_we_clr", m_we, 0);
    mem_wr  = 1'b0;
    m_ready = 1'b0;
    step();
    check_val("pri_idle_freeze", freeze, 1);
    check_val("pri_mem_done_end", mem_done, 0);
    step();
    check_val("pri_state_if", dbg_state, S_GNT_IF);
    check_val("pri_if_m_addr", m_addr, 32'h20);
    check_val("pri_if_m_we", m_we, 0);
    check_val("pri_starve0", dbg_starve, 0);
    m_ready = 1'b1;
    m_rdata = 32'hCAFEF00D;
    step();
    check_val("pri_if_done", if_done, 1);
    check_val("pri_if_rdata", if_rdata, 32'hCAFEF00D);
    if_req  = 1'b0;
    m_ready = 1'b0;
    step();

    // Starvation: IF held, MEM read reasserted every IDLE
    if_req  = 1'b1;
    if_addr = 32'h30;
    for (int k = 0; k < 3; k++) begin
      mem_rd   = 1'b1;
      mem_addr = 32'h100 + k;
      step();
      check_val("stv_state_mem", dbg_state, S_GNT_MEM);
      check_val("stv_m_addr", m_addr, 32'h100 + k);
      check_val("stv_count", dbg_starve, k + 1);
      m_ready = 1'b1;
      m_rdata = 32'hA0 + k;
      step();
      check_val("stv_mem_done", mem_done, 1);
      check_val("stv_mem_rdata", mem_rdata, 32'hA0 + k);
      m_ready = 1'b0;
      step();
    end
    mem_addr = 32'h1FF;
    step();
    check_val("stv_state_if", dbg_state, S_GNT_IF);
    check_val("stv_if_m_addr", m_addr, 32'h30);
    check_val("stv_count_clr", dbg_starve, 0);
    m_ready = 1'b1;
    m_rdata = 32'h3333;
    step();
    check_val("stv_if_done", if_done, 1);
    check_val("stv_if_rdata", if_rdata, 32'h3333);
    check_val("stv_mem_done_quiet", mem_done, 0);
    check_val("stv_mem_rdata_kept", mem_rdata, 32'hA2);
    if_req  = 1'b0;
    mem_rd  = 1'b0;
    m_ready = 1'b0;
    step();

    // Variable latency: m_ready after 5 waiting cycles
    mem_rd   = 1'b1;
    mem_addr = 32'h200;
    step();
    for (int i = 0; i < 5; i++) begin
      check_val("lat_m_req", m_req, 1);
      check_val("lat_m_addr", m_addr, 32'h200);
      check_val("lat_freeze", freeze, 1);
      check_val("lat_no_done", mem_done, 0);
      step();
    end
    m_ready = 1'b1;
    m_rdata = 32'h77;
    step();
    check_val("lat_mem_done", mem_done, 1);
    check_val("lat_mem_rdata", mem_rdata, 32'h77);
    mem_rd  = 1'b0;
    m_ready = 1'b0;
    step();
    check_val("lat_done_single", mem_done, 0);
    check_val("lat_idle", dbg_state, S_IDLE);

    // Read and write together: treated as a write
    mem_rd    = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 32'h300;
    mem_wdata = 32'h99;
    step();
    check_val("rw_m_we", m_we, 1);
    check_val("rw_m_wdata", m_wdata, 32'h99);
    m_ready = 1'b1;
    m_rdata = 32'h1234;
    step();
    check_val("rw_mem_done", mem_done, 1);
    check_val("rw_mem_rdata_kept", mem_rdata, 32'h77);
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    m_ready = 1'b0;
    step();

    // Reset in GNT_MEM, late m_ready discarded
    mem_rd   = 1'b1;
    mem_addr = 32'h400;
    step();
    check_val("mrst_state_mem", dbg_state, S_GNT_MEM);
    rst = 1'b0;
    step();
    check_val("mrst_m_req", m_req, 0);
    check_val("mrst_state", dbg_state, S_IDLE);
    check_val("mrst_mem_done", mem_done, 0);
    rst    = 1'b1;
    mem_rd = 1'b0;
    step();
    m_ready = 1'b1;
    m_rdata = 32'hBAD;
    step();
    check_val("mrst_late_state", dbg_state, S_IDLE);
    check_val("mrst_late_done", mem_done, 0);
    check_val("mrst_mem_rdata", mem_rdata, 0);
    check_val("mrst_if_rdata", if_rdata, 0);
    check_val("mrst_m_req_late", m_req, 0);
    m_ready = 1'b0;
    step();
    check_val("mrst_final_done", mem_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; STARVE_MAX, default 3, max consecutive MEM grants while IF waits.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 if_req  in  1  fetch stage read request, held until if_done.
REQ-005 if_addr  in  ADDR_W  fetch address.
REQ-006 if_rdata  out  DATA_W  registered fetch data, valid when if_done=1.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 mem_rd  in  1  data stage read request, held until mem_done.
REQ-009 mem_wr  in  1  data stage write request, held until mem_done.
REQ-010 mem_addr  in  ADDR_W  data address.
REQ-011 mem_wdata  in  DATA_W  write data.
REQ-012 mem_rdata  out  DATA_W  registered load data, valid when mem_done=1.
REQ-013 mem_done  out  1  one-cycle data completion pulse.
REQ-014 freeze  out  1  pipeline stall, combinational from state and requests.
REQ-015 m_req  out  1  shared memory request, registered.
REQ-016 m_we  out  1  shared memory write enable, registered.
REQ-017 m_addr  out  ADDR_W  shared memory address, registered.
REQ-018 m_wdata  out  DATA_W  shared memory write data, registered.
REQ-019 m_rdata  in  DATA_W  shared memory read data, valid with m_ready.
REQ-020 m_ready  in  1  shared memory completion, one cycle, any latency >=1 after m_req.

Function
REQ-021 FSM states: IDLE, GNT_IF, GNT_MEM, RESP; exactly one active.
REQ-022 IDLE: MEM request (mem_rd|mem_wr) wins over if_req, unless if_req=1 and starve count = STARVE_MAX, then IF wins.
REQ-023 On grant: latch address (and m_wdata, m_we=mem_wr for MEM; m_we=0 for IF), set m_req=1, enter GNT_IF/GNT_MEM next cycle.
REQ-024 mem_rd and mem_wr both high: treated as write; mem_rdata unchanged.
REQ-025 GNT_x: m_req, m_addr, m_we, m_wdata held stable until m_ready=1.
REQ-026 GNT_x with m_ready=1: m_req and m_we cleared; for reads, m_rdata captured into if_rdata or mem_rdata; next state RESP.
REQ-027 RESP: lasts one cycle; the granted requester's done is 1 in this cycle only; no new grant evaluated; next state IDLE.
REQ-028 Minimum latency: request in IDLE at cycle N, m_ready at N+1 -> done at N+2; next grant evaluated at N+3.
REQ-029 m_ready in IDLE or RESP ignored; no state or data change.
REQ-030 Starve count: increments (saturating at STARVE_MAX) on each MEM grant while if_req=1; clears on each IF grant; unchanged otherwise.
REQ-031 freeze=1 in GNT_IF, GNT_MEM, and in IDLE when any request asserted; freeze=0 in RESP and in IDLE with no request.
REQ-032 Non-granted requester's rdata and done unchanged while other requester is served.

Reset
REQ-033 rst=0 at a rising edge: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0, starve count=0.
REQ-034 Reset mid-transaction abandons it: no done pulse, m_req low the cycle after the reset edge, late m_ready discarded.
REQ-035 While rst=0 no grant occurs regardless of requests; freeze follows REQ-031 from the IDLE state.

Verification
REQ-036 IF only: if_req=1, if_addr=0x10, m_ready one cycle after m_req with m_rdata=0xDEADBEEF -> m_we=0, m_addr=0x10, if_done one cycle later with if_rdata=0xDEADBEEF, freeze=0 that cycle.
REQ-037 Simultaneous if_req and mem_wr (mem_addr=0x40, mem_wdata=0x55) -> MEM served first (m_we=1, m_addr=0x40), mem_done, then IF served; if_done after mem_done.
REQ-038 Starvation: if_req held, mem_rd reasserted every IDLE, STARVE_MAX=3 -> 3 MEM grants then IF grant, count back to 0.
REQ-039 Variable latency: m_ready delayed 5 cycles -> m_req/m_addr stable for all 5, freeze=1 throughout, single done pulse.
REQ-040 Reset in GNT_MEM with m_ready arriving 2 cycles later -> m_req=0 after reset edge, no mem_done, mem_rdata=0, state IDLE.
REQ-041 mem_rd and mem_wr both high -> m_we=1, mem_done pulses, mem_rdata unchanged.
